program_loader: RTL

//   Boot-time byte-stream loader sitting upstream of processor_32_bit. Receives a framed

---
 rtl/program_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time loader: parses a framed byte stream, writes big-endian 32-bit words to RAM and
// releases the core from reset once a frame with a matching XOR checksum has been written.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  restart,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  core_reset,
   output logic                  load_done,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      StSync, StLenHi, StLenLo, StData, StCsum, StDone, StError
   } state_e;

   state_e                state_q;
   logic [7:0]            csum_q;
   logic [7:0]            len_hi_q;
   logic [15:0]           len_q;
   logic [15:0]           word_cnt_q;
   logic [1:0]            byte_cnt_q;
   logic [23:0]           word_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_en_q;
   logic                  accept;
   logic [15:0]           len_full;

   assign in_ready = (state_q != StDone) && (state_q != StError) && !restart;
   assign accept   = in_valid && in_ready;
   // A write pending in the restart cycle is dropped so a stale word never lands in RAM.
   assign wr_en    = wr_en_q && !restart;
   assign len_full = {len_hi_q, in_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StSync;
         csum_q     <= 8'h00;
         len_hi_q   <= 8'h00;
         len_q      <= 16'h0000;
         word_cnt_q <= 16'h0000;
         byte_cnt_q <= 2'd0;
         word_q     <= 24'h000000;
         addr_q     <= BASE_ADDR;
         wr_en_q    <= 1'b0;
         wr_addr    <= BASE_ADDR;
         wr_data    <= 32'h0000_0000;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (restart) begin
            state_q    <= StSync;
            csum_q     <= 8'h00;
            len_hi_q   <= 8'h00;
            len_q      <= 16'h0000;
            word_cnt_q <= 16'h0000;
            byte_cnt_q <= 2'd0;
            addr_q     <= BASE_ADDR;
            wr_addr    <= BASE_ADDR;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
         end else if (accept) begin
            case (state_q)
               StSync: begin
                  if (in_data == SYNC_BYTE) begin
                     csum_q  <= 8'h00;
                     state_q <= StLenHi;
                  end
               end
               StLenHi: begin
                  len_hi_q <= in_data;
                  csum_q   <= csum_q ^ in_data;
                  state_q  <= StLenLo;
               end
               StLenLo: begin
                  csum_q <= csum_q ^ in_data;
                  len_q  <= len_full;
                  if (32'(len_full) > MAX_WORDS) begin
                     state_q    <= StError;
                     load_error <= 1'b1;
                  end else if (len_full == 16'h0000) begin
                     state_q <= StCsum;
                  end else begin
                     state_q <= StData;
                  end
               end
               StData: begin
                  csum_q     <= csum_q ^ in_data;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0: word_q[23:16] <= in_data;
                     2'd1: word_q[15:8]  <= in_data;
                     2'd2: word_q[7:0]   <= in_data;
                     default: begin
                        wr_en_q    <= 1'b1;
                        wr_data    <= {word_q, in_data};
                        wr_addr    <= addr_q;
                        addr_q     <= addr_q + 1'b1;
                        word_cnt_q <= word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) state_q <= StCsum;
                     end
                  endcase
               end
               StCsum: begin
                  if (in_data == csum_q) begin
                     state_q    <= StDone;
                     load_done  <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     state_q    <= StError;
                     load_error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
